// File: rtl/ln_affine_pipe.sv
// Row-wise affine normalisation: out = sat8(((sat9(((x - mean) * inv_std) << alpha >> SHIFT_N) * gamma) >> SHIFT_G) + beta)
// Three registered stages with a single backpressure-driven enable and a four-state row controller.
module ln_affine_pipe #(
    parameter int COUNT     = 128,
    parameter int CNT_WIDTH = 8,
    parameter int SHIFT_N   = 8,
    parameter int SHIFT_G   = 6
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic signed [21:0] i_mean,
    input  logic        [7:0]  i_inv_std,
    input  logic        [1:0]  i_alpha,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic signed [8:0]  i_x,
    input  logic signed [7:0]  i_gamma,
    input  logic signed [7:0]  i_beta,
    output logic               o_valid,
    input  logic               i_out_ready,
    output logic signed [7:0]  o_norm,
    output logic               o_last,
    output logic               o_done,
    output logic               o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(COUNT - 1);

    function automatic logic signed [8:0] sat9(input logic signed [34:0] v);
        logic signed [8:0] r;
        if (v > 35'sd255) begin
            r = 9'sd255;
        end else if (v < -35'sd256) begin
            r = 9'sh100;
        end else begin
            r = v[8:0];
        end
        return r;
    endfunction

    function automatic logic signed [7:0] sat8(input logic signed [16:0] v);
        logic signed [7:0] r;
        if (v > 17'sd127) begin
            r = 8'sd127;
        end else if (v < -17'sd128) begin
            r = 8'sh80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic signed [21:0]     mean_q;
    logic        [7:0]      inv_q;
    logic        [1:0]      alpha_q;
    logic [CNT_WIDTH-1:0]   in_cnt_q, out_cnt_q;
    logic                   s1_vld_q, s2_vld_q, vld_q, err_q;
    logic signed [22:0]     s1_d_q;
    logic signed [7:0]      s1_g_q, s1_b_q, s2_g_q, s2_b_q, norm_q;
    logic signed [8:0]      s2_n_q;

    logic                   en_s, acc_s, hs_s, last_s, start_ok_s;
    logic signed [22:0]     d_s;
    logic signed [34:0]     prod_n_s;
    logic signed [8:0]      n_s;
    logic signed [16:0]     prod_g_s, sum_s;
    logic signed [7:0]      norm_s;

    assign en_s       = !(vld_q && !i_out_ready);
    assign acc_s      = (state_q == RUN) && en_s && i_valid;
    assign hs_s       = vld_q && i_out_ready;
    assign last_s     = vld_q && (out_cnt_q == LAST_IDX);
    assign start_ok_s = (state_q == IDLE) && i_start;

    assign o_ready = (state_q == RUN) && en_s;
    assign o_valid = vld_q;
    assign o_norm  = norm_q;
    assign o_last  = last_s;
    assign o_done  = (state_q == DONE);
    assign o_err   = err_q;

    // Datapath arithmetic for all three stages; inv_std is zero-extended so it multiplies as unsigned.
    always_comb begin
        d_s      = $signed({{14{i_x[8]}}, i_x}) - $signed({mean_q[21], mean_q});
        prod_n_s = $signed({{12{s1_d_q[22]}}, s1_d_q}) * $signed({27'd0, inv_q});
        n_s      = sat9((prod_n_s <<< alpha_q) >>> SHIFT_N);
        prod_g_s = $signed({{8{s2_n_q[8]}}, s2_n_q}) * $signed({{9{s2_g_q[7]}}, s2_g_q});
        sum_s    = (prod_g_s >>> SHIFT_G) + $signed({{9{s2_b_q[7]}}, s2_b_q});
        norm_s   = sat8(sum_s);
    end

    // Row controller next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = RUN;
                else         state_d = IDLE;
            end
            RUN: begin
                if (acc_s && (in_cnt_q == LAST_IDX)) state_d = FLUSH;
                else                                 state_d = RUN;
            end
            FLUSH: begin
                if (hs_s && last_s) state_d = DONE;
                else                state_d = FLUSH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Row parameters are frozen only when a row is accepted from IDLE.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mean_q  <= 22'sd0;
            inv_q   <= 8'd0;
            alpha_q <= 2'd0;
        end else if (start_ok_s) begin
            mean_q  <= i_mean;
            inv_q   <= i_inv_std;
            alpha_q <= i_alpha;
        end
    end

    // Input/output element counters saturate at the last index so they never wrap inside a row.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else if (start_ok_s) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (acc_s && (in_cnt_q != LAST_IDX))   in_cnt_q  <= in_cnt_q + 1'b1;
            if (hs_s && (out_cnt_q != LAST_IDX))   out_cnt_q <= out_cnt_q + 1'b1;
        end
    end

    // Pipeline stages; everything freezes while the output is stalled, gamma/beta ride with the element.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_vld_q <= 1'b0;
            s1_d_q   <= 23'sd0;
            s1_g_q   <= 8'sd0;
            s1_b_q   <= 8'sd0;
            s2_vld_q <= 1'b0;
            s2_n_q   <= 9'sd0;
            s2_g_q   <= 8'sd0;
            s2_b_q   <= 8'sd0;
            vld_q    <= 1'b0;
            norm_q   <= 8'sd0;
        end else if (en_s) begin
            s1_vld_q <= acc_s;
            s2_vld_q <= s1_vld_q;
            vld_q    <= s2_vld_q;
            if (acc_s) begin
                s1_d_q <= d_s;
                s1_g_q <= i_gamma;
                s1_b_q <= i_beta;
            end
            if (s1_vld_q) begin
                s2_n_q <= n_s;
                s2_g_q <= s1_g_q;
                s2_b_q <= s1_b_q;
            end
            if (s2_vld_q) norm_q <= norm_s;
        end
    end

    // A start outside IDLE is a protocol violation and is reported for one cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) err_q <= 1'b0;
        else         err_q <= i_start && (state_q != IDLE);
    end

endmodule

// File: tb/tb_ln_affine_pipe.sv
// Directed self-checking bench for ln_affine_pipe: single-element vectors, full rows with
// backpressure, protocol violations and mid-row reset.
module tb_ln_affine_pipe;

    logic               clk;
    logic               rstn;
    logic               start;
    logic signed [21:0] mean;
    logic        [7:0]  inv;
    logic        [1:0]  alpha;
    logic               valid;
    logic               ordy;
    logic signed [8:0]  x;
    logic signed [7:0]  g;
    logic signed [7:0]  b;
    logic               ovalid;
    logic               out_ready;
    logic signed [7:0]  norm;
    logic               last;
    logic               done;
    logic               err;

    int n_cmp = 0;
    int n_bad = 0;

    ln_affine_pipe dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_mean      (mean),
        .i_inv_std   (inv),
        .i_alpha     (alpha),
        .i_valid     (valid),
        .o_ready     (ordy),
        .i_x         (x),
        .i_gamma     (g),
        .i_beta      (b),
        .o_valid     (ovalid),
        .i_out_ready (out_ready),
        .o_norm      (norm),
        .o_last      (last),
        .o_done      (done),
        .o_err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference arithmetic written directly from the mathematical definition.
    function automatic logic signed [7:0] model(input int mean_v, input int inv_v, input int alpha_v,
                                                input int x_v, input int g_v, input int b_v);
        longint d, p, n, r;
        d = longint'(x_v) - longint'(mean_v);
        p = d * longint'(inv_v);
        for (int k = 0; k < alpha_v; k++) p = p * 2;
        n = p >>> 8;
        if (n > 255) n = 255;
        else if (n < -256) n = -256;
        r = ((n * longint'(g_v)) >>> 6) + longint'(b_v);
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
        return 8'(r);
    endfunction

    function automatic int xval(input int i, input int pat);
        return ((i * 37 + pat * 11) % 512) - 256;
    endfunction

    function automatic int gval(input int i, input int pat);
        return ((i * 53 + pat) % 256) - 128;
    endfunction

    function automatic int bval(input int i);
        return ((i * 29) % 64) - 32;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; start = 1'b0; valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; mean = '0; inv = '0; alpha = '0;
        valid = 1'b0; x = '0; g = '0; b = '0; out_ready = 1'b1;
        #1;
        n_cmp++;
        if ({ovalid, ordy, norm, last, done, err} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required all zero", {ovalid, ordy, norm, last, done, err});
        end
        @(negedge clk);
        rstn = 1'b1;
        valid = 1'b1;
        #1;
        n_cmp++;
        if (ordy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_ready: got %b required 0", ordy);
        end
        @(negedge clk);
        valid = 1'b0;
        n_cmp++;
        if (ovalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_valid: got %b required 0", ovalid);
        end
    endtask

    task automatic test_single(input string name, input int m, input int iv, input int a,
                               input int xv, input int gv, input int bv, input logic signed [7:0] expv);
        do_reset();
        @(negedge clk);
        start = 1'b1; mean = 22'(m); inv = 8'(iv); alpha = 2'(a);
        @(negedge clk);
        start = 1'b0; mean = 22'(m + 77); inv = 8'(iv ^ 85); alpha = 2'(a + 1);
        valid = 1'b1; x = 9'(xv); g = 8'(gv); b = 8'(bv); out_ready = 1'b1;
        #1;
        n_cmp++;
        if (ordy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_ready: got %b required 1", name, ordy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            valid = 1'b0;
            n_cmp++;
            if (ovalid !== (c == 2)) begin
                n_bad++;
                $display("FAIL %s_latency c%0d: o_valid got %b required %b", name, c, ovalid, c == 2);
            end
        end
        n_cmp++;
        if (norm !== expv) begin
            n_bad++;
            $display("FAIL %s_value: got %0d required %0d", name, norm, expv);
        end
        n_cmp++;
        if (last !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_last: got %b required 0", name, last);
        end
    endtask

    task automatic test_protocol_violation();
        int nout;
        nout = 0;
        do_reset();
        @(negedge clk);
        start = 1'b1; mean = 22'sd36; inv = 8'd128; alpha = 2'd0;
        @(negedge clk);
        start = 1'b0; valid = 1'b1; x = 9'sd100; g = 8'sd64; b = 8'sd0; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1; mean = -22'sd100;
            end else begin
                start = 1'b0;
            end
            if (c == 3 || c == 4) begin
                n_cmp++;
                if (err !== (c == 3)) begin
                    n_bad++;
                    $display("FAIL viol_err c%0d: got %b required %b", c, err, c == 3);
                end
            end
            if (ovalid) begin
                nout++;
                n_cmp++;
                if (norm !== 8'sd32) begin
                    n_bad++;
                    $display("FAIL viol_value c%0d: got %0d required 32", c, norm);
                end
            end
            #1;
            if (c == 5) begin
                n_cmp++;
                if (ordy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL viol_still_run: o_ready got %b required 1", ordy);
                end
            end
        end
        n_cmp++;
        if (nout !== 10) begin
            n_bad++;
            $display("FAIL viol_count: got %0d outputs required 10", nout);
        end
        valid = 1'b0;
    endtask

    task automatic run_row(input bit stalls, input int pat);
        logic signed [7:0] expq [128];
        logic signed [7:0] prev_norm;
        logic              prev_last, stall_prev, done_exp, got_done;
        int m, iv, a, ii, oi, cyc;
        m  = (pat == 0) ? -20 : 30;
        iv = (pat == 0) ? 180 : 90;
        a  = (pat == 0) ? 1 : 2;
        for (int i = 0; i < 128; i++) expq[i] = model(m, iv, a, xval(i, pat), gval(i, pat), bval(i));
        @(negedge clk);
        start = 1'b1; mean = 22'(m); inv = 8'(iv); alpha = 2'(a); valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ii = 0; oi = 0; cyc = 0;
        prev_norm = '0; prev_last = 1'b0; stall_prev = 1'b0; done_exp = 1'b0; got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            cyc++;
            if (stall_prev) begin
                n_cmp++;
                if (ovalid !== 1'b1 || norm !== prev_norm || last !== prev_last) begin
                    n_bad++;
                    $display("FAIL row_stall_hold: got v=%b n=%0d l=%b required v=1 n=%0d l=%b",
                             ovalid, norm, last, prev_norm, prev_last);
                end
            end
            n_cmp++;
            if (done !== done_exp) begin
                n_bad++;
                $display("FAIL row_done cyc%0d: got %b required %b", cyc, done, done_exp);
            end
            if (done && done_exp) begin
                got_done = 1'b1;
                start = 1'b1; mean = 22'sd5;
            end
            done_exp = 1'b0;
            valid = (ii < 128);
            x = 9'(xval(ii, pat)); g = 8'(gval(ii, pat)); b = 8'(bval(ii));
            out_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (!stalls && ii < 128) begin
                n_cmp++;
                if (ordy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL row_throughput elem%0d: o_ready got %b required 1", ii, ordy);
                end
            end
            if (valid && ordy) ii++;
            if (ovalid && out_ready) begin
                n_cmp++;
                if (oi >= 128) begin
                    n_bad++;
                    $display("FAIL row_extra_output: got output %0d required at most 128", oi);
                end else if (norm !== expq[oi] || last !== (oi == 127)) begin
                    n_bad++;
                    $display("FAIL row_output %0d: got n=%0d l=%b required n=%0d l=%b",
                             oi, norm, last, expq[oi], oi == 127);
                end
                if (oi == 127) done_exp = 1'b1;
                oi++;
            end
            stall_prev = ovalid && !out_ready;
            prev_norm = norm;
            prev_last = last;
            @(negedge clk);
        end
        n_cmp++;
        if (!got_done || ii != 128 || oi != 128) begin
            n_bad++;
            $display("FAIL row_complete: got done=%b in=%0d out=%0d required done=1 in=128 out=128",
                     got_done, ii, oi);
        end
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL row_start_in_done: got err=%b done=%b required err=1 done=0", err, done);
        end
        start = 1'b0; valid = 1'b1;
        #1;
        n_cmp++;
        if (ordy !== 1'b0) begin
            n_bad++;
            $display("FAIL row_back_to_idle: o_ready got %b required 0", ordy);
        end
        @(negedge clk);
        valid = 1'b0;
        n_cmp++;
        if (ovalid !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL row_quiet_after: got v=%b err=%b required 0 0", ovalid, err);
        end
    endtask

    task automatic test_full_row();
        do_reset();
        run_row(1'b1, 0);
    endtask

    task automatic test_reset_mid_row();
        int acc, guard;
        do_reset();
        @(negedge clk);
        start = 1'b1; mean = 22'sd30; inv = 8'd90; alpha = 2'd2;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        acc = 0; guard = 0;
        while (acc < 50 && guard < 200) begin
            guard++;
            valid = 1'b1; x = 9'(xval(acc, 1)); g = 8'(gval(acc, 1)); b = 8'(bval(acc));
            #1;
            if (ordy) acc++;
            @(negedge clk);
        end
        n_cmp++;
        if (acc != 50 || ovalid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrow_setup: got accepts=%0d v=%b required 50 1", acc, ovalid);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({ovalid, ordy, norm, last, done, err} !== 13'd0) begin
            n_bad++;
            $display("FAIL midrow_reset_outputs: got %b required all zero", {ovalid, ordy, norm, last, done, err});
        end
        @(negedge clk);
        valid = 1'b0;
        rstn = 1'b1;
        run_row(1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_single("basic",   36,   128, 0,  100,  64,  0, 8'sd32);
        test_single("pos_sat", -255, 255, 3,  255, 127, 10, 8'sd127);
        test_single("neg_sat", 0,    255, 0, -200,  64,  0, 8'sh80);
        test_protocol_violation();
        test_full_row();
        test_reset_mid_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
